// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
//  state_t     : FSM state encoding (IDLE / WAIT / DONE)
//  XLEN        : datapath width
//  DM_TIMEOUT  : default abort limit, in WAIT cycles without an ack
//  DM_CNT_W    : default wait-counter width
package dmem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int XLEN       = 32;
   localparam int DM_TIMEOUT = 255;
   localparam int DM_CNT_W   = 8;

endpackage

// File: rtl/dmem_access_ctrl_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory request.
//  clk_i    in  clock, rising edge
//  rst_i    in  async reset, active-low
//  clear    in  return count to zero (wins over enable)
//  enable   in  count up by one this cycle
//  expired  out count has reached TIMEOUT_CYCLES-1
module wait_timer
   import dmem_access_ctrl_pkg::*;
#(
   parameter int CNT_W          = DM_CNT_W,
   parameter int TIMEOUT_CYCLES = DM_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Runs a req/ack handshake with data memory for each load/store, freezes the
// upstream pipeline while the access is outstanding and bubbles MEM/WB so a
// partial load result is never written back. Aborts a hung access after
// TIMEOUT_CYCLES WAIT cycles and flags it on a sticky timeout_o.
//  clk_i, rst_i            clock / async active-low reset
//  MemRead_i, MemWrite_i   access request from EX/MEM (both set = write)
//  addr_i, wdata_i         address / store data from EX/MEM
//  dm_req_o, dm_we_o       memory request and direction (registered)
//  dm_addr_o, dm_wdata_o   latched address / store data
//  dm_ack_i, dm_rdata_i    memory completion pulse and read data
//  stall_o, bubble_o       pipeline hold and MEM/WB bubble (combinational)
//  DMdata_o                captured load data towards MEM/WB
//  timeout_o               sticky abort flag, cleared only by reset
//
// state | meaning
// IDLE  | no access; a new load/store stalls the pipe and issues the request
// WAIT  | request outstanding; pipe stalled, MEM/WB bubbled, counting cycles
// DONE  | access finished (ack or abort); pipe released for exactly one cycle
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DM_TIMEOUT,
   parameter int CNT_W          = DM_CNT_W
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            MemRead_i,
   input  logic            MemWrite_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            dm_req_o,
   output logic            dm_we_o,
   output logic [XLEN-1:0] dm_addr_o,
   output logic [XLEN-1:0] dm_wdata_o,
   input  logic            dm_ack_i,
   input  logic [XLEN-1:0] dm_rdata_i,
   output logic            stall_o,
   output logic            bubble_o,
   output logic [XLEN-1:0] DMdata_o,
   output logic            timeout_o
);

   state_t state, state_nxt;
   logic   access;
   logic   in_wait;
   logic   expired;

   assign access  = MemRead_i | MemWrite_i;
   assign in_wait = (state == ST_WAIT);

   wait_timer #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (!in_wait || dm_ack_i || expired),
      .enable  (in_wait),
      .expired (expired)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (access) state_nxt = ST_WAIT;
         ST_WAIT: if (dm_ack_i || expired) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The stall must appear in the same cycle the load/store shows up in
   // IDLE, so it is decoded from the inputs rather than registered. Reset
   // gates it so an asserted MemRead_i cannot hold the pipe during reset.
   always_comb begin
      stall_o = 1'b0;
      case (state)
         ST_IDLE: stall_o = access;
         ST_WAIT: stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
      stall_o  = stall_o & rst_i;
      bubble_o = stall_o;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dm_req_o   <= 1'b0;
         dm_we_o    <= 1'b0;
         dm_addr_o  <= '0;
         dm_wdata_o <= '0;
         DMdata_o   <= '0;
         timeout_o  <= 1'b0;
      end else begin
         if (state == ST_IDLE && access) begin
            dm_req_o   <= 1'b1;
            dm_we_o    <= MemWrite_i;
            dm_addr_o  <= addr_i;
            dm_wdata_o <= wdata_i;
         end else if (in_wait) begin
            // Ack has priority over a coinciding timeout.
            if (dm_ack_i) begin
               dm_req_o <= 1'b0;
               if (!dm_we_o) DMdata_o <= dm_rdata_i;
            end else if (expired) begin
               dm_req_o  <= 1'b0;
               timeout_o <= 1'b1;
               DMdata_o  <= '0;
            end
         end
      end
   end

endmodule
